// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: LSB-first square-and-multiply sequencer that drives an external Montgomery multiplier.
// Optional macro MONT_EXP_EARLY_EXIT_EN stops as soon as the remaining exponent bits are all zero.
module mont_exp_ctrl #(
  parameter int EXP_BITS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [256:0]        s_in,
  input  logic [EXP_BITS-1:0] e,
  output logic                ma_start,
  output logic [255:0]        ma_a,
  output logic [255:0]        ma_b,
  input  logic [256:0]        ma_v,
  input  logic                ma_ready,
  output logic [255:0]        result,
  output logic                done,
  output logic                busy,
  output logic                err
);

  localparam int CNT_W = $clog2(EXP_BITS + 1);

  typedef enum logic [2:0] {IDLE, CHK, MUL, MUL_W, SQR, SQR_W, FIN} state_t;

  state_t              state, state_nxt;
  logic [255:0]        r, t;
  logic [EXP_BITS-1:0] x;
  logic [CNT_W-1:0]    cnt;
  logic                armed;
  logic                accept;
  logic                unused_s_in_msb;

  // armed stays low for the first wait cycle so a ready left over from the previous product is never taken
  assign accept          = armed && ma_ready;
  assign unused_s_in_msb = s_in[256];

`ifdef MONT_EXP_EARLY_EXIT_EN
  logic rest_zero;
  assign rest_zero = (x >> 1) == '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ma_start  = 1'b0;
    ma_a      = '0;
    ma_b      = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = CHK;
      CHK: begin
        if (cnt == CNT_W'(EXP_BITS)) state_nxt = FIN;
`ifdef MONT_EXP_EARLY_EXIT_EN
        else if (x == '0)            state_nxt = FIN;
`endif
        else if (x[0])               state_nxt = MUL;
        else                         state_nxt = SQR;
      end
      MUL: begin
        ma_start  = 1'b1;
        ma_a      = r;
        ma_b      = t;
        state_nxt = MUL_W;
      end
      MUL_W: begin
        ma_a = r;
        ma_b = t;
        if (accept) begin
`ifdef MONT_EXP_EARLY_EXIT_EN
          state_nxt = rest_zero ? FIN : SQR;
`else
          state_nxt = SQR;
`endif
        end
      end
      SQR: begin
        ma_start  = 1'b1;
        ma_a      = t;
        ma_b      = t;
        state_nxt = SQR_W;
      end
      SQR_W: begin
        ma_a = t;
        ma_b = t;
        if (accept) state_nxt = CHK;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // R accumulates in the normal domain (1 * M * ...), T holds the Montgomery-form base powers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r      <= '0;
      t      <= '0;
      x      <= '0;
      cnt    <= '0;
      armed  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t   <= s_in[255:0];
            x   <= e;
            r   <= 256'd1;
            cnt <= '0;
            err <= 1'b0;
          end
        end
        MUL, SQR: armed <= 1'b0;
        MUL_W: begin
          armed <= 1'b1;
          if (accept) begin
            r <= ma_v[255:0];
            if (ma_v[256]) err <= 1'b1;
          end
        end
        SQR_W: begin
          armed <= 1'b1;
          if (accept) begin
            t   <= ma_v[255:0];
            x   <= x >> 1;
            cnt <= cnt + 1'b1;
            if (ma_v[256]) err <= 1'b1;
          end
        end
        FIN: begin
          result <= r;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameter EXP_BITS, default 256: number of exponent bits processed, LSB first.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request pulse; sampled only in IDLE.
REQ-005 SHALL have port s_in, input, 257: pre-processed base M*2^256 mod N, from the pre-processing stage.
REQ-006 SHALL have port e, input, EXP_BITS: exponent.
REQ-007 SHALL have port ma_start, output, 1: one-cycle start pulse to the Montgomery multiplier.
REQ-008 SHALL have ports ma_a and ma_b, output, 256 each: multiplier operands, stable from the ma_start cycle until ma_ready is accepted.
REQ-009 SHALL have port ma_v, input, 257: multiplier result.
REQ-010 SHALL have port ma_ready, input, 1: multiplier result valid (level).
REQ-011 SHALL have port result, output, 256: M^e mod N, held until the next start.
REQ-012 SHALL have ports done, output, 1 (one-cycle pulse), and busy, output, 1 (high in every non-IDLE state).
REQ-013 SHALL have port err, output, 1: sticky flag set when an accepted ma_v has bit 256 set; cleared on start.

Function
REQ-014 SHALL implement FSM states IDLE, CHK, MUL, MUL_W, SQR, SQR_W, FIN.
REQ-015 IDLE: start=1 SHALL latch T<=s_in[255:0], X<=e, R<=1, cnt<=0, err<=0, and go to CHK; start=0 SHALL stay in IDLE.
REQ-016 CHK: cnt==EXP_BITS SHALL go to FIN; otherwise X[0]=1 SHALL go to MUL, and X[0]=0 SHALL go to SQR.
REQ-017 MUL SHALL drive ma_start=1, ma_a=R, ma_b=T for exactly one cycle, then go to MUL_W.
REQ-018 SQR SHALL drive ma_start=1, ma_a=T, ma_b=T for exactly one cycle, then go to SQR_W.
REQ-019 In MUL_W and SQR_W, ma_ready SHALL be ignored in the first cycle after entry, which masks stale ready; from the second cycle, ma_ready=1 SHALL be accepted.
REQ-020 On acceptance in MUL_W, R SHALL be loaded with ma_v[255:0] and the FSM SHALL go to SQR.
REQ-021 On acceptance in SQR_W, T SHALL be loaded with ma_v[255:0], X shifted right by 1, cnt incremented, and the FSM SHALL go to CHK.
REQ-022 R SHALL stay in the normal domain: R starts at 1 and each MUL computes R*M; no final conversion multiply is needed.
REQ-023 FIN SHALL copy R to result, pulse done=1 for one cycle, and return to IDLE.
REQ-024 start outside IDLE SHALL be ignored, with no change to latched operands.
REQ-025 ma_ready in IDLE, CHK, MUL, SQR or FIN SHALL be ignored.
REQ-026 cnt SHALL be wide enough to hold EXP_BITS without wrap.

Reset
REQ-027 rst_n=0 SHALL force state IDLE and result, R, T, X, cnt, done, busy, err, ma_start, ma_a and ma_b all to 0, asynchronously, including mid-operation.
REQ-028 After reset release, the first start SHALL begin a clean operation with no residue from the aborted one.

Configuration
REQ-029 Macro MONT_EXP_EARLY_EXIT_EN SHALL control early termination.
REQ-030 With MONT_EXP_EARLY_EXIT_EN defined, CHK SHALL go to FIN when X==0.
REQ-031 With MONT_EXP_EARLY_EXIT_EN defined, MUL_W acceptance SHALL go to FIN instead of SQR when X[EXP_BITS-1:1]==0, skipping squarings that cannot change the result.
REQ-032 Without MONT_EXP_EARLY_EXIT_EN, exactly EXP_BITS squarings SHALL always be issued.

Verification (behavioural MA model: ready drops the cycle after ma_start and rises 3 cycles after it, returns A*B*2^-256 mod N)
REQ-033 Reset with start=1 asserted -> all outputs 0 and busy=0; no ma_start pulse until after release.
REQ-034 N=13, M=7, s_in=7*2^256 mod 13, e=5 -> result=11, one done pulse, err=0, in both configurations.
REQ-035 e=0 -> result=1; with the macro: 0 ma_start pulses and done 2 cycles after start; without it: 256 ma_start pulses.
REQ-036 e=1 -> result=M mod N; with the macro: 1 ma_start pulse; without it: 257 pulses.
REQ-037 e=all-ones, with start re-pulsed mid-run -> second start ignored; 512 ma_start pulses; result matches reference modexp.
REQ-038 rst_n pulsed low during SQR_W -> immediate IDLE with all outputs 0; a new start then yields the correct result; ma_v[256]=1 injected -> err=1 until the next start.
